axi4_lite_arbiter: RTL
======================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default DEFAULT_AXI_ADDR_WIDTH, meaning address width of all ports.
REQ-002 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, reset); one clock, reset asynchronous active-low.
REQ-003 SHALL have, for each requester N in {0,1} (0 = instruction fetch, 1 = data load/store), these ports:
- pN_rd_en (in, 1, read request)
- pN_wr_en (in, 1, write request)
- pN_addr (in, ADDR_WIDTH, address)
- pN_wr_data (in, 32, write data)
- pN_wr_strobe (in, 4, byte strobes)
REQ-004 SHALL provide, for each N, pN_rd_data (out, 32), pN_access_fault (out, 1) and pN_busy (out, 1).
REQ-005 SHALL have manager-side outputs mgr_rd_en, mgr_wr_en (1), mgr_addr (ADDR_WIDTH), mgr_wr_data (32) and mgr_wr_strobe (4).
REQ-006 SHALL have manager-side inputs mgr_rd_data (32), mgr_access_fault (1) and mgr_busy (1).

Function
REQ-007 Requester protocol: request held until a cycle with pN_busy=0 while the request is asserted; that cycle is completion, and rd_data/access_fault are valid only then.
REQ-008 States:
- IDLE: no transaction owned.
- GRANT0: port 0 owns the manager.
- GRANT1: port 1 owns the manager.
REQ-009 IDLE, requests present: the winner (REQ-016) is forwarded combinationally to mgr_* in the same cycle (zero added latency), and its addr/data/strobe/rd_en/wr_en are latched.
REQ-010 IDLE, winner gets mgr_busy=0 the same cycle: completion is immediate and the state stays IDLE. Winner gets mgr_busy=1: next state is GRANTn for the winner.
REQ-011 GRANTn: mgr_* are driven from the latched request, not the live pN inputs. The live inputs are ignored until completion.
REQ-012 GRANTn, mgr_busy=0: completion for port n and next state IDLE. A new grant is possible no earlier than the following cycle.
REQ-013 Owner outputs: pN_busy = mgr_busy, pN_rd_data = mgr_rd_data, pN_access_fault = mgr_access_fault.
REQ-014 Non-owner outputs: pN_busy = (pN_rd_en | pN_wr_en), pN_rd_data = 0, pN_access_fault = 0.
REQ-015 IDLE with no request: all mgr_* outputs are 0 and all pN_busy are 0.
REQ-016 Fixed priority: port 1 (data) beats port 0 on simultaneous requests.
REQ-017 pN_rd_en and pN_wr_en asserted together are forwarded together unchanged.
REQ-018 Dropping a request mid-grant does not abort the transaction; the latched request completes.
REQ-019 Invalid state encoding: next state is IDLE and mgr_* outputs are 0.

Reset
REQ-020 rst_n=0 asynchronously forces state IDLE, clears all latches and the rr_last pointer, and drives every output to 0, including pN_busy.
REQ-021 Reset mid-GRANT abandons the transaction; no completion is signalled.
REQ-022 The first request after reset release is arbitrated as in IDLE.

Configuration
REQ-023 Macro AXI_ARB_ROUND_ROBIN_EN. Defined: a 1-bit register rr_last records the last completed owner; on a tie, the port other than rr_last wins; rr_last updates on each completion. Undefined: fixed priority per REQ-016 and no rr_last register.

Verification
REQ-024 Single read: p0_rd_en=1, addr=0x100, mgr_busy=1 for 3 cycles then 0 with mgr_rd_data=0xDEADBEEF -> p0_busy high 3 cycles, p0_rd_data=0xDEADBEEF on cycle 4, p1 outputs 0.
REQ-025 Tie: p0_rd_en and p1_wr_en both asserted in IDLE -> mgr_wr_en=1 with p1_addr. With the macro undefined, p1 wins again on repeat. With it defined, p0 wins on repeat.
REQ-026 Stability: p1_addr changed 0x200->0x300 during GRANT1 -> mgr_addr stays 0x200 until completion.
REQ-027 Zero-wait: mgr_busy=0 in the request cycle -> completion the same cycle and the state remains IDLE.
REQ-028 Fault and reset: mgr_access_fault=1 at completion -> only the owner's fault output is 1. rst_n low mid-GRANT0 -> all outputs 0 immediately, and the next request is granted from IDLE.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
// Two-requester (fetch/data) arbiter onto one AXI4-Lite-style manager port; 0-cycle grant, owner held until mgr_busy drops.
// Latency: zero added (winner forwarded combinationally). Backpressure: mgr_busy to owner, pN_busy=request to loser.
// Optional AXI_ARB_ROUND_ROBIN_EN: ties alternate via rr_last instead of fixed port-1 priority.
`ifndef DEFAULT_AXI_ADDR_WIDTH
`define DEFAULT_AXI_ADDR_WIDTH 32
`endif

module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = `DEFAULT_AXI_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_rd_en,
    input  logic                  p0_wr_en,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wr_data,
    input  logic [3:0]            p0_wr_strobe,
    output logic [31:0]           p0_rd_data,
    output logic                  p0_access_fault,
    output logic                  p0_busy,
    input  logic                  p1_rd_en,
    input  logic                  p1_wr_en,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wr_data,
    input  logic [3:0]            p1_wr_strobe,
    output logic [31:0]           p1_rd_data,
    output logic                  p1_access_fault,
    output logic                  p1_busy,
    output logic                  mgr_rd_en,
    output logic                  mgr_wr_en,
    output logic [ADDR_WIDTH-1:0] mgr_addr,
    output logic [31:0]           mgr_wr_data,
    output logic [3:0]            mgr_wr_strobe,
    input  logic [31:0]           mgr_rd_data,
    input  logic                  mgr_access_fault,
    input  logic                  mgr_busy
);

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
        logic [3:0]            strb;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    req_t   lat_q, lat_d;
    req_t   live0, live1, mgr_req;
    logic   req0, req1, pick1, own0, own1;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic rr_last_q, rr_last_d;
`endif

    assign live0 = '{rd: p0_rd_en, wr: p0_wr_en, addr: p0_addr, data: p0_wr_data, strb: p0_wr_strobe};
    assign live1 = '{rd: p1_rd_en, wr: p1_wr_en, addr: p1_addr, data: p1_wr_data, strb: p1_wr_strobe};
    assign req0  = p0_rd_en | p0_wr_en;
    assign req1  = p1_rd_en | p1_wr_en;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        mgr_req = '0;
        own0    = 1'b0;
        own1    = 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
        // On a tie the port that did not complete last goes first.
        pick1   = req1 & (~req0 | ~rr_last_q);
`else
        pick1   = req1;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    mgr_req = pick1 ? live1 : live0;
                    lat_d   = mgr_req;
                    own0    = ~pick1;
                    own1    = pick1;
                    if (mgr_busy) begin
                        state_d = pick1 ? GRANT1 : GRANT0;
                    end
                end
            end
            GRANT0: begin
                mgr_req = lat_q;
                own0    = 1'b1;
                if (!mgr_busy) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                mgr_req = lat_q;
                own1    = 1'b1;
                if (!mgr_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef AXI_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if ((own0 | own1) && !mgr_busy) begin
            rr_last_d = own1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_q     <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_last_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Outputs are forced low while reset is held, even though requests are live.
    assign mgr_rd_en       = rst_n & mgr_req.rd;
    assign mgr_wr_en       = rst_n & mgr_req.wr;
    assign mgr_addr        = rst_n ? mgr_req.addr : '0;
    assign mgr_wr_data     = rst_n ? mgr_req.data : '0;
    assign mgr_wr_strobe   = rst_n ? mgr_req.strb : '0;

    assign p0_busy         = rst_n & (own0 ? mgr_busy : req0);
    assign p0_rd_data      = (rst_n & own0) ? mgr_rd_data : '0;
    assign p0_access_fault = rst_n & own0 & mgr_access_fault;
    assign p1_busy         = rst_n & (own1 ? mgr_busy : req1);
    assign p1_rd_data      = (rst_n & own1) ? mgr_rd_data : '0;
    assign p1_access_fault = rst_n & own1 & mgr_access_fault;

endmodule
